// File: rtl/div_sched_if.sv
// div_sched_if: requester/response bus of the shared-divider scheduler.
//   master : requester side (drives jobs, accepts results)
//   slave  : scheduler side (grants jobs, presents tagged results)
// Signals:
//   req_valid    [NREQ]     per-requester job valid
//   req_ready    [NREQ]     one-hot grant/accept
//   req_dividend [NREQ*DW]  packed operands, lane i = [i*DW +: DW]
//   req_divisor  [NREQ*DW]  packed operands, lane i = [i*DW +: DW]
//   rsp_valid/rsp_ready     result handshake
//   rsp_id, rsp_quotient, rsp_remainder, rsp_dbz  result payload
interface div_sched_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_dividend;
  logic [NREQ*DW-1:0] req_divisor;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_quotient;
  logic [DW-1:0]      rsp_remainder;
  logic               rsp_dbz;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
  );
endinterface

// File: rtl/div_sched.sv
// div_sched: shares one sequential restoring divider among NREQ requesters.
// Round-robin grant, registered job operands, tagged valid/ready responses.
// The divider is pulsed through reset (div_rst_n) after every job.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     requester/response bus, see div_sched_if
//   div_start       one-cycle start pulse to the divider
//   div_dividend    job dividend, held from accept until the next accept
//   div_divisor     job divisor, held from accept until the next accept
//   div_quotient    divider quotient
//   div_remainder   divider remainder
//   div_done        divider done level
//   div_rst_n       registered active-low divider reset
//
// Optional feature: define DIV_ZERO_BYPASS_EN to answer zero-divisor jobs
// directly (quotient all ones, remainder = dividend, rsp_dbz = 1).
module div_sched #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  div_sched_if.slave    bus,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  input  logic [DW-1:0] div_quotient,
  input  logic [DW-1:0] div_remainder,
  input  logic          div_done,
  output logic          div_rst_n
);
  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StResp, StClear} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, id_q;
  logic [DW-1:0]   dvd_q, dvs_q, quo_q, rem_q;
  logic            div_rst_n_q;
  logic            grant_found;
  logic [IW-1:0]   grant_id;
  logic [IW:0]     scan_sum;
  logic [IW-1:0]   scan_lane;
  logic [DW-1:0]   grant_dvd, grant_dvs;
  logic [NREQ-1:0] req_ready;
  logic            accept, resp_live, rsp_fire;
`ifdef DIV_ZERO_BYPASS_EN
  logic            dbz_q;
  // Set for the cycle after a zero-divisor accept while the response loads.
  logic            zero_pend_q;
`endif

  // Round-robin scan: first valid lane starting at ptr, wrapping mod NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = ptr_q;
    scan_sum    = '0;
    scan_lane   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_sum  = {1'b0, ptr_q} + (IW+1)'(k);
      scan_lane = (scan_sum >= (IW+1)'(NREQ)) ? IW'(scan_sum - (IW+1)'(NREQ)) : IW'(scan_sum);
      if (!grant_found && bus.req_valid[scan_lane]) begin
        grant_found = 1'b1;
        grant_id    = scan_lane;
      end
    end
  end

  always_comb begin
    grant_dvd = '0;
    grant_dvs = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_id == IW'(k)) begin
        grant_dvd = bus.req_dividend[k*DW +: DW];
        grant_dvs = bus.req_divisor[k*DW +: DW];
      end
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  assign resp_live = (state_q == StResp) && !zero_pend_q;
`else
  assign resp_live = (state_q == StResp);
`endif
  assign rsp_fire = resp_live && bus.rsp_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    accept    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          accept              = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_d             = StStart;
`ifdef DIV_ZERO_BYPASS_EN
          if (grant_dvs == '0) state_d = StResp;
`endif
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (div_done) state_d = StResp;
      end
      StResp: begin
        if (rsp_fire) begin
          ptr_d   = (id_q == IW'(NREQ-1)) ? '0 : id_q + 1'b1;
          state_d = StClear;
`ifdef DIV_ZERO_BYPASS_EN
          // The divider never ran, so there is nothing to clear.
          if (dbz_q) state_d = StIdle;
`endif
        end
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_rst_n_q <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q       <= 1'b0;
      zero_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      // Low for exactly the CLEAR cycle; also low while rst is held.
      div_rst_n_q <= (state_d != StClear);
      if (accept) begin
        id_q  <= grant_id;
        dvd_q <= grant_dvd;
        dvs_q <= grant_dvs;
      end
      if (state_q == StWait && div_done) begin
        quo_q <= div_quotient;
        rem_q <= div_remainder;
      end
`ifdef DIV_ZERO_BYPASS_EN
      if (accept) dbz_q <= 1'b0;
      zero_pend_q <= accept && (grant_dvs == '0);
      if (zero_pend_q) begin
        quo_q <= '1;
        rem_q <= dvd_q;
        dbz_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = resp_live;
  assign bus.rsp_id        = id_q;
  assign bus.rsp_quotient  = quo_q;
  assign bus.rsp_remainder = rem_q;
`ifdef DIV_ZERO_BYPASS_EN
  assign bus.rsp_dbz       = dbz_q;
`else
  assign bus.rsp_dbz       = 1'b0;
`endif
  assign div_start    = (state_q == StStart);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_rst_n    = div_rst_n_q;
endmodule
